game_sequencer: RTL and testbench

Game-flow controller for the Pong datapath: sequences IDLE → SERVE → PLAY → MISS → GAME OVER, and gates the ball logic through a serve pulse and a motion enable. It counts paddle hits as a two-digit BCD score and tracks remaining lives. It sits between the hit/miss sources (Hit_Detector, ball edge logic) and the ball position/direction blocks, and is paced by the VGA frame-reset pulse.

---
 rtl/game_sequencer.sv | 164 ++++++++++++++++
 tb/tb_game_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Game-flow controller for the Pong datapath.
// Sequences IDLE -> SERVE -> PLAY -> MISS -> OVER.
// Gates the ball logic through a serve pulse and a motion enable.
// Keeps a two-digit BCD score of paddle hits and the remaining lives.
// Frame-based delays are paced by the VGA frame-start pulse.
//
// Ports:
//   i_Clk         system/pixel clock
//   i_Reset       asynchronous, active-high reset
//   i_VReset      one-cycle frame-start pulse
//   i_Start       raw start switch (asynchronous, synchronized here)
//   i_Hit         ball/paddle overlap level
//   i_Miss        one-cycle pulse when the ball passes the paddle-side edge
//   o_Serve       one-cycle pulse that recentres the ball
//   o_Ball_Enable ball motion allowed
//   o_State       state encoding (IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4)
//   o_Score       BCD score, tens in [7:4], units in [3:0]
//   o_Lives       remaining lives
//   o_Game_Over   high while in OVER
module game_sequencer #(
  parameter int unsigned p_LIVES        = 3,
  parameter int unsigned p_SERVE_FRAMES = 60,
  parameter int unsigned p_MISS_FRAMES  = 30
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_VReset,
  input  logic       i_Start,
  input  logic       i_Hit,
  input  logic       i_Miss,
  output logic       o_Serve,
  output logic       o_Ball_Enable,
  output logic [2:0] o_State,
  output logic [7:0] o_Score,
  output logic [1:0] o_Lives,
  output logic       o_Game_Over
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StMiss  = 3'd3,
    StOver  = 3'd4
  } state_e;

  localparam logic [1:0] LivesInit   = 2'(p_LIVES);
  localparam logic [7:0] ServeFrames = 8'(p_SERVE_FRAMES);
  localparam logic [7:0] MissFrames  = 8'(p_MISS_FRAMES);

  state_e      state_q, state_d;
  logic        start_meta_q, start_sync_q, start_prev_q;
  logic        hit_prev_q, hit_lock_q, hit_lock_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic        serve_q, serve_d;
  logic        enable_q, enable_d;
  logic        game_over_q, game_over_d;

  logic        start_evt, hit_edge, hit_scored, serve_done, miss_done;

  assign start_evt  = start_sync_q & ~start_prev_q;
  assign hit_edge   = i_Hit & ~hit_prev_q;
  // A miss in the same cycle wins over a hit edge.
  assign hit_scored = (state_q == StPlay) && hit_edge && !hit_lock_q && !i_Miss;
  assign serve_done = i_VReset && (frame_cnt_q + 8'd1 == ServeFrames);
  assign miss_done  = i_VReset && (frame_cnt_q + 8'd1 == MissFrames);

  // State register.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StOver: if (start_evt)  state_d = StServe;
      StServe:        if (serve_done) state_d = StPlay;
      StPlay:         if (i_Miss)     state_d = (lives_q <= 2'd1) ? StOver : StMiss;
      StMiss:         if (miss_done)  state_d = StServe;
      default:                        state_d = StIdle;
    endcase
  end

  // Output and datapath next values; every output is registered below.
  always_comb begin
    score_d     = score_q;
    lives_d     = lives_q;
    hit_lock_d  = hit_lock_q;
    frame_cnt_d = frame_cnt_q;
    serve_d     = (state_d == StServe) && (state_q != StServe);
    enable_d    = (state_d == StPlay);
    game_over_d = (state_d == StOver);

    // Lock clears on the frame pulse but a coincident scored hit re-arms it.
    if (i_VReset)   hit_lock_d = 1'b0;
    if (hit_scored) hit_lock_d = 1'b1;

    if (hit_scored && (score_q != 8'h99)) begin
      if (score_q[3:0] == 4'd9) begin
        score_d = {score_q[7:4] + 4'd1, 4'd0};
      end else begin
        score_d = {score_q[7:4], score_q[3:0] + 4'd1};
      end
    end

    if ((state_q == StPlay) && i_Miss && (lives_q != 2'd0)) begin
      lives_d = lives_q - 2'd1;
    end

    if (((state_q == StIdle) || (state_q == StOver)) && start_evt) begin
      score_d = 8'h00;
      lives_d = LivesInit;
    end

    if (state_d != state_q) begin
      frame_cnt_d = 8'd0;
    end else if (i_VReset && ((state_q == StServe) || (state_q == StMiss))) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      start_meta_q <= 1'b0;
      start_sync_q <= 1'b0;
      start_prev_q <= 1'b0;
      hit_prev_q   <= 1'b0;
      hit_lock_q   <= 1'b0;
      frame_cnt_q  <= 8'd0;
      score_q      <= 8'h00;
      lives_q      <= LivesInit;
      serve_q      <= 1'b0;
      enable_q     <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      start_meta_q <= i_Start;
      start_sync_q <= start_meta_q;
      start_prev_q <= start_sync_q;
      hit_prev_q   <= i_Hit;
      hit_lock_q   <= hit_lock_d;
      frame_cnt_q  <= frame_cnt_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      serve_q      <= serve_d;
      enable_q     <= enable_d;
      game_over_q  <= game_over_d;
    end
  end

  assign o_State       = state_q;
  assign o_Score       = score_q;
  assign o_Lives       = lives_q;
  assign o_Serve       = serve_q;
  assign o_Ball_Enable = enable_q;
  assign o_Game_Over   = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer (3 lives, 2 serve frames, 3 miss frames).
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst, vreset, start, hit, miss;
  logic       serve, ball_en, game_over;
  logic [2:0] state;
  logic [7:0] score;
  logic [1:0] lives;

  int tests  = 0;
  int errors = 0;

  game_sequencer #(
    .p_LIVES       (3),
    .p_SERVE_FRAMES(2),
    .p_MISS_FRAMES (3)
  ) dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_VReset     (vreset),
    .i_Start      (start),
    .i_Hit        (hit),
    .i_Miss       (miss),
    .o_Serve      (serve),
    .o_Ball_Enable(ball_en),
    .o_State      (state),
    .o_Score      (score),
    .o_Lives      (lives),
    .o_Game_Over  (game_over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vframe();
    vreset = 1'b1;
    tick();
    vreset = 1'b0;
    tick();
  endtask

  task automatic hit_frame();
    hit = 1'b1;
    tick();
    hit = 1'b0;
    tick();
    vframe();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    tests++; if (score !== 8'h00) begin errors++; $display("FAIL reset_score: got %h want 00", score); end
    tests++; if (lives !== 2'd3) begin errors++; $display("FAIL reset_lives: got %0d want 3", lives); end
    tests++; if ({serve, ball_en, game_over} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {serve, ball_en, game_over});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_start();
    start = 1'b1;
    tick();
    tests++; if (state !== 3'd0) begin errors++; $display("FAIL start_edge1: got %0d want 0", state); end
    tick();
    tests++; if (state !== 3'd0) begin errors++; $display("FAIL start_edge2: got %0d want 0", state); end
    tick();
    tests++; if (state !== 3'd1) begin errors++; $display("FAIL start_edge3: got %0d want 1", state); end
    tests++; if (serve !== 1'b1) begin errors++; $display("FAIL start_serve_hi: got %b want 1", serve); end
    tests++; if (lives !== 2'd3 || score !== 8'h00) begin
      errors++; $display("FAIL start_load: got lives %0d score %h want 3 00", lives, score);
    end
    tick();
    tests++; if (serve !== 1'b0) begin errors++; $display("FAIL start_serve_lo: got %b want 0", serve); end
    start = 1'b0;
  endtask

  task automatic test_serve();
    vreset = 1'b1;
    tick();
    vreset = 1'b0;
    tests++; if (ball_en !== 1'b0 || state !== 3'd1) begin
      errors++; $display("FAIL serve_early: got en %b state %0d want 0 1", ball_en, state);
    end
    tick();
    vreset = 1'b1;
    tick();
    vreset = 1'b0;
    tests++; if (ball_en !== 1'b1 || state !== 3'd2) begin
      errors++; $display("FAIL serve_play: got en %b state %0d want 1 2", ball_en, state);
    end
    tick();
  endtask

  task automatic test_scoring();
    hit = 1'b1;
    tick();
    hit = 1'b0;
    tests++; if (score !== 8'h01) begin errors++; $display("FAIL score_first: got %h want 01", score); end
    tick();
    vframe();
    for (int i = 2; i <= 12; i++) begin
      hit_frame();
      if (i == 10) begin
        tests++; if (score !== 8'h10) begin errors++; $display("FAIL score_carry: got %h want 10", score); end
      end
    end
    tests++; if (score !== 8'h12) begin errors++; $display("FAIL score_12: got %h want 12", score); end
    // Held level across three frames counts once.
    hit = 1'b1;
    tick();
    vframe();
    vframe();
    vframe();
    hit = 1'b0;
    tick();
    tests++; if (score !== 8'h13) begin errors++; $display("FAIL score_held: got %h want 13", score); end
    // Two edges in one frame count once.
    hit = 1'b1; tick(); hit = 1'b0; tick();
    hit = 1'b1; tick(); hit = 1'b0; tick();
    tests++; if (score !== 8'h14) begin errors++; $display("FAIL score_lock: got %h want 14", score); end
    vframe();
    // Hit coincident with the frame pulse scores and keeps the lock for the new frame.
    hit = 1'b1; vreset = 1'b1;
    tick();
    hit = 1'b0; vreset = 1'b0;
    tests++; if (score !== 8'h15) begin errors++; $display("FAIL score_vsync_hit: got %h want 15", score); end
    tick();
    hit = 1'b1; tick(); hit = 1'b0; tick();
    tests++; if (score !== 8'h15) begin errors++; $display("FAIL score_vsync_lock: got %h want 15", score); end
    vframe();
  endtask

  task automatic test_miss_simul();
    hit = 1'b1; miss = 1'b1;
    tick();
    hit = 1'b0; miss = 1'b0;
    tests++; if (score !== 8'h15 || lives !== 2'd2) begin
      errors++; $display("FAIL simul_score_lives: got %h %0d want 15 2", score, lives);
    end
    tests++; if (state !== 3'd3 || ball_en !== 1'b0) begin
      errors++; $display("FAIL simul_state: got state %0d en %b want 3 0", state, ball_en);
    end
    tick();
    hit = 1'b1; tick(); hit = 1'b0; tick();
    tests++; if (score !== 8'h15) begin errors++; $display("FAIL miss_hit_ignored: got %h want 15", score); end
    vframe();
    vframe();
    tests++; if (state !== 3'd3) begin errors++; $display("FAIL miss_hold: got %0d want 3", state); end
    vreset = 1'b1;
    tick();
    vreset = 1'b0;
    tests++; if (state !== 3'd1 || serve !== 1'b1) begin
      errors++; $display("FAIL miss_to_serve: got state %0d serve %b want 1 1", state, serve);
    end
    tick();
    tests++; if (serve !== 1'b0) begin errors++; $display("FAIL miss_serve_lo: got %b want 0", serve); end
    vframe();
    vframe();
    tests++; if (state !== 3'd2 || ball_en !== 1'b1) begin
      errors++; $display("FAIL reserve_play: got state %0d en %b want 2 1", state, ball_en);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 84; i++) hit_frame();
    tests++; if (score !== 8'h99) begin errors++; $display("FAIL score_99: got %h want 99", score); end
    hit_frame();
    tests++; if (score !== 8'h99) begin errors++; $display("FAIL score_sat: got %h want 99", score); end
  endtask

  task automatic test_game_over();
    miss = 1'b1; tick(); miss = 1'b0;
    tests++; if (lives !== 2'd1 || state !== 3'd3) begin
      errors++; $display("FAIL miss2: got lives %0d state %0d want 1 3", lives, state);
    end
    vframe(); vframe(); vframe();
    vframe(); vframe();
    tests++; if (state !== 3'd2) begin errors++; $display("FAIL play3: got %0d want 2", state); end
    miss = 1'b1; tick(); miss = 1'b0;
    tests++; if (lives !== 2'd0 || state !== 3'd4 || game_over !== 1'b1 || ball_en !== 1'b0) begin
      errors++; $display("FAIL over: got lives %0d state %0d go %b en %b want 0 4 1 0",
                         lives, state, game_over, ball_en);
    end
    hit_frame();
    miss = 1'b1; tick(); miss = 1'b0; tick();
    tests++; if (score !== 8'h99 || lives !== 2'd0 || state !== 3'd4) begin
      errors++; $display("FAIL over_hold: got %h %0d %0d want 99 0 4", score, lives, state);
    end
    start = 1'b1;
    tick();
    tick();
    tests++; if (state !== 3'd4) begin errors++; $display("FAIL restart_early: got %0d want 4", state); end
    tick();
    tests++; if (state !== 3'd1 || score !== 8'h00 || lives !== 2'd3 || game_over !== 1'b0 ||
                 serve !== 1'b1) begin
      errors++; $display("FAIL restart: got st %0d sc %h lv %0d go %b sv %b want 1 00 3 0 1",
                         state, score, lives, game_over, serve);
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    vframe(); vframe();
    miss = 1'b1; tick(); miss = 1'b0;
    vframe();
    tests++; if (state !== 3'd3 || lives !== 2'd2) begin
      errors++; $display("FAIL pre_reset: got state %0d lives %0d want 3 2", state, lives);
    end
    #3;
    rst = 1'b1;
    #1;
    tests++; if (state !== 3'd0 || lives !== 2'd3 || score !== 8'h00 ||
                 {serve, ball_en, game_over} !== 3'b000) begin
      errors++; $display("FAIL async_reset: got st %0d lv %0d sc %h flags %b want 0 3 00 000",
                         state, lives, score, {serve, ball_en, game_over});
    end
    tick();
    rst = 1'b0;
    tick();
    tick();
    tests++; if (state !== 3'd0) begin errors++; $display("FAIL post_reset_idle: got %0d want 0", state); end
    start = 1'b1;
    tick();
    tick();
    tests++; if (state !== 3'd0) begin errors++; $display("FAIL post_reset_early: got %0d want 0", state); end
    tick();
    tests++; if (state !== 3'd1 || serve !== 1'b1) begin
      errors++; $display("FAIL post_reset_start: got state %0d serve %b want 1 1", state, serve);
    end
    tick();
    tests++; if (serve !== 1'b0) begin errors++; $display("FAIL post_reset_serve_lo: got %b want 0", serve); end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vreset = 1'b0; start = 1'b0; hit = 1'b0; miss = 1'b0;
    test_reset();
    test_start();
    test_serve();
    test_scoring();
    test_miss_simul();
    test_saturate();
    test_game_over();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
